// File: rtl/corr_scan_ctrl_pkg.sv
// Shared definitions for the correlator run-sequencer.
//   state_t    : sequencer states
//   DIR_*      : encodings of the direction verdict
//   MIN_LENGTH : shortest legal correlator window
//   dir_from   : turns the two vote comparisons into a direction code
//   cfg_legal  : accepts or rejects a requested run configuration
package corr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        FILL    = 3'd2,
        MEASURE = 3'd3,
        REPORT  = 3'd4
    } state_t;

    localparam logic [1:0] DIR_TIE = 2'b00;
    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_NEG = 2'b10;

    localparam logic [7:0] MIN_LENGTH = 8'd2;

    // pos_gt and neg_gt are never both set; a tie falls through to DIR_TIE.
    function automatic logic [1:0] dir_from(input logic pos_gt, input logic neg_gt);
        if (pos_gt)
            return DIR_POS;
        else if (neg_gt)
            return DIR_NEG;
        else
            return DIR_TIE;
    endfunction

    function automatic logic cfg_legal(input logic [7:0] length, input logic [7:0] frames);
        return (length >= MIN_LENGTH) && (frames != 8'd0);
    endfunction

endpackage

// File: rtl/corr_scan_ctrl_if.sv
// Result port of the run-sequencer (valid/ready handshake plus payload).
//   res_valid    : result available (master -> slave)
//   res_ready    : consumer ready (slave -> master)
//   res_dir      : direction verdict
//   res_pos_cnt  : pos votes counted during MEASURE
//   res_neg_cnt  : neg votes counted during MEASURE
//   res_corr_min : minimum corr seen during MEASURE
interface corr_scan_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_dir;
    logic [CNT_W-1:0] res_pos_cnt;
    logic [CNT_W-1:0] res_neg_cnt;
    logic [7:0]       res_corr_min;

    modport master (
        output res_valid,
        output res_dir,
        output res_pos_cnt,
        output res_neg_cnt,
        output res_corr_min,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_dir,
        input  res_pos_cnt,
        input  res_neg_cnt,
        input  res_corr_min,
        output res_ready
    );
endinterface

// File: rtl/corr_scan_ctrl_sat_counter.sv
// Saturating up-counter used for the pos/neg vote tallies.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one when set
//   cnt      : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/corr_scan_ctrl.sv
// Run-sequencer for the PDM cross-correlator buffer.
// Holds the correlator in reset between runs, flushes it, lets the window
// fill, then tallies pos/neg lead flags and the minimum zero-lag mismatch
// over F frames of L cycles, and hands the verdict out on a valid/ready port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | correlator held in reset, waiting for a legal start
//   FLUSH   | correlator held in reset for FLUSH_CYCLES cycles
//   FILL    | correlator running, L cycles while the window fills
//   MEASURE | F*L cycles of vote counting and min tracking
//   REPORT  | publish result (first cycle), then wait for res_ready
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, abort             : run request / run cancel
//   cfg_length, cfg_frames   : window length L and frame count F
//   corr, pos, neg           : correlator outputs
//   corr_rst, corr_length    : correlator controls (registered)
//   busy, cfg_err            : status
//   res                      : result port (master side)
module corr_scan_ctrl
    import corr_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_length,
    input  logic [7:0] cfg_frames,
    input  logic [7:0] corr,
    input  logic       pos,
    input  logic       neg,
    output logic       corr_rst,
    output logic [7:0] corr_length,
    output logic       busy,
    output logic       cfg_err,
    corr_scan_ctrl_if.master res
);

    // Within-frame timer is at least 8 bits so any legal window fits.
    localparam int CYC_W = (CNT_W > 8) ? CNT_W : 8;

    state_t           state, state_nxt;
    logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
    logic [7:0]       frm_cnt, frm_nxt;
    logic [7:0]       len_q, len_nxt;
    logic [7:0]       frames_q, frames_nxt;
    logic [7:0]       min_q, min_nxt;
    logic             clr_votes;
    logic             meas;
    logic             res_load;
    logic             valid_nxt;
    logic             cfg_err_nxt;
    logic [CNT_W-1:0] pos_cnt, neg_cnt;
    logic [CYC_W-1:0] len_m1;

    assign len_m1 = CYC_W'(len_q) - CYC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc_cnt;
        frm_nxt     = frm_cnt;
        len_nxt     = len_q;
        frames_nxt  = frames_q;
        min_nxt     = min_q;
        clr_votes   = 1'b0;
        meas        = 1'b0;
        res_load    = 1'b0;
        valid_nxt   = res.res_valid;
        cfg_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (!cfg_legal(cfg_length, cfg_frames)) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        state_nxt  = FLUSH;
                        len_nxt    = cfg_length;
                        frames_nxt = cfg_frames;
                        cyc_nxt    = CYC_W'(FLUSH_CYCLES - 1);
                        clr_votes  = 1'b1;
                        min_nxt    = 8'hFF;
                    end
                end
            end

            FLUSH: begin
                if (cyc_cnt == '0) begin
                    state_nxt = FILL;
                    cyc_nxt   = len_m1;
                end else begin
                    cyc_nxt = cyc_cnt - CYC_W'(1);
                end
            end

            FILL: begin
                if (cyc_cnt == '0) begin
                    state_nxt = MEASURE;
                    cyc_nxt   = len_m1;
                    frm_nxt   = frames_q - 8'd1;
                end else begin
                    cyc_nxt = cyc_cnt - CYC_W'(1);
                end
            end

            MEASURE: begin
                meas    = 1'b1;
                min_nxt = (corr < min_q) ? corr : min_q;
                if (cyc_cnt == '0) begin
                    if (frm_cnt == 8'd0) begin
                        state_nxt = REPORT;
                    end else begin
                        frm_nxt = frm_cnt - 8'd1;
                        cyc_nxt = len_m1;
                    end
                end else begin
                    cyc_nxt = cyc_cnt - CYC_W'(1);
                end
            end

            REPORT: begin
                // Counters settle on the REPORT entry edge; the result is
                // captured one cycle later and then held until consumed.
                if (!res.res_valid) begin
                    res_load  = 1'b1;
                    valid_nxt = 1'b1;
                end else if (res.res_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            res_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt          <= '0;
            frm_cnt          <= '0;
            len_q            <= MIN_LENGTH;
            frames_q         <= '0;
            min_q            <= 8'hFF;
            corr_rst         <= 1'b1;
            busy             <= 1'b0;
            cfg_err          <= 1'b0;
            res.res_valid    <= 1'b0;
            res.res_dir      <= DIR_TIE;
            res.res_pos_cnt  <= '0;
            res.res_neg_cnt  <= '0;
            res.res_corr_min <= 8'hFF;
        end else begin
            cyc_cnt       <= cyc_nxt;
            frm_cnt       <= frm_nxt;
            len_q         <= len_nxt;
            frames_q      <= frames_nxt;
            min_q         <= min_nxt;
            corr_rst      <= !((state_nxt == FILL) || (state_nxt == MEASURE));
            busy          <= (state_nxt == FLUSH) || (state_nxt == FILL) ||
                             (state_nxt == MEASURE);
            cfg_err       <= cfg_err_nxt;
            res.res_valid <= valid_nxt;
            if (res_load) begin
                res.res_dir      <= dir_from(pos_cnt > neg_cnt, neg_cnt > pos_cnt);
                res.res_pos_cnt  <= pos_cnt;
                res.res_neg_cnt  <= neg_cnt;
                res.res_corr_min <= min_q;
            end
        end
    end

    assign corr_length = len_q;

    sat_counter #(.CNT_W(CNT_W)) u_pos_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_votes),
        .inc (meas && pos),
        .cnt (pos_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_neg_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_votes),
        .inc (meas && neg),
        .cnt (neg_cnt)
    );

endmodule

// File: tb/tb_corr_scan_ctrl.sv
// Directed bench for corr_scan_ctrl: a vector table for a full legal run
// plus hand-written sequences for tie/backpressure, config rejection,
// abort, vote saturation (second instance with 4-bit counters) and
// asynchronous reset.
module tb_corr_scan_ctrl;
    import corr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start, abort, start_s, abort_s;
    logic [7:0] cfg_length, cfg_frames, corr;
    logic       pos, neg;
    logic       corr_rst, busy, cfg_err;
    logic [7:0] corr_length;
    logic       corr_rst_s, busy_s, cfg_err_s;
    logic [7:0] corr_length_s;

    corr_scan_ctrl_if #(.CNT_W(16)) rif ();
    corr_scan_ctrl_if #(.CNT_W(4))  sif ();

    corr_scan_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_length(cfg_length), .cfg_frames(cfg_frames),
        .corr(corr), .pos(pos), .neg(neg),
        .corr_rst(corr_rst), .corr_length(corr_length),
        .busy(busy), .cfg_err(cfg_err), .res(rif)
    );

    corr_scan_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
        .cfg_length(cfg_length), .cfg_frames(cfg_frames),
        .corr(corr), .pos(pos), .neg(neg),
        .corr_rst(corr_rst_s), .corr_length(corr_length_s),
        .busy(busy_s), .cfg_err(cfg_err_s), .res(sif)
    );

    typedef struct {
        logic       start;
        logic       pos;
        logic       neg;
        logic [7:0] corr;
        logic       ready;
        logic       exp_rst;
        logic       exp_busy;
        logic       exp_valid;
    } vec_t;

    vec_t       vt[17];
    logic [7:0] cseq[8] = '{8'd9, 8'd7, 8'd5, 8'd3, 8'd3, 8'd4, 8'd6, 8'd8};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_main(input int budget, output int n);
        n = 0;
        while (!rif.res_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_valid_sat(input int budget, output int n);
        n = 0;
        while (!sif.res_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    int         lat;
    logic       stable, seen;
    logic [1:0] h_dir;
    logic [15:0] h_pc, h_nc;
    logic [7:0] h_min;

    initial begin
        // Entry i drives inputs sampled at edge i; expectations hold after it.
        // Edge 0 accepts start; FLUSH 0..1, FILL 2..5, MEASURE 6..13
        // (samples at edges 7..14), REPORT from 14, res_valid at 15.
        for (int i = 0; i < 17; i++) begin
            vt[i].start     = (i == 0);
            vt[i].pos       = (i >= 7 && i <= 14);
            vt[i].neg       = (i >= 1 && i <= 6);
            vt[i].corr      = (i >= 7 && i <= 14) ? cseq[i-7] : 8'd0;
            vt[i].ready     = (i == 16);
            vt[i].exp_rst   = !(i >= 2 && i <= 13);
            vt[i].exp_busy  = (i <= 13);
            vt[i].exp_valid = (i == 15);
        end

        rst = 1'b1;
        start = 0; abort = 0; start_s = 0; abort_s = 0;
        cfg_length = 0; cfg_frames = 0; corr = 0; pos = 0; neg = 0;
        rif.res_ready = 0; sif.res_ready = 0;
        #12;
        chk("rst_corr_rst", corr_rst, 1'b1);
        chk("rst_corr_length", corr_length, 8'd2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_valid", rif.res_valid, 1'b0);
        chk("rst_dir", rif.res_dir, 2'b00);
        chk("rst_pos_cnt", rif.res_pos_cnt, 16'd0);
        chk("rst_neg_cnt", rif.res_neg_cnt, 16'd0);
        chk("rst_min", rif.res_corr_min, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

        // Legal run L=4, F=2 from the vector table.
        cfg_length = 8'd4;
        cfg_frames = 8'd2;
        for (int i = 0; i < 17; i++) begin
            start         = vt[i].start;
            pos           = vt[i].pos;
            neg           = vt[i].neg;
            corr          = vt[i].corr;
            rif.res_ready = vt[i].ready;
            tick();
            chk($sformatf("run1_corr_rst[%0d]", i), corr_rst, vt[i].exp_rst);
            chk($sformatf("run1_busy[%0d]", i), busy, vt[i].exp_busy);
            chk($sformatf("run1_valid[%0d]", i), rif.res_valid, vt[i].exp_valid);
            if (i == 0) chk("run1_corr_length", corr_length, 8'd4);
            if (i == 15) begin
                chk("run1_dir", rif.res_dir, DIR_POS);
                chk("run1_pos_cnt", rif.res_pos_cnt, 16'd8);
                chk("run1_neg_cnt", rif.res_neg_cnt, 16'd0);
                chk("run1_min", rif.res_corr_min, 8'd3);
            end
        end
        start = 0; rif.res_ready = 0; pos = 0; neg = 0;

        // Tie and backpressure: L=3, F=1, samples at edges 6,7,8 with
        // pos=neg=edge[0] -> 0,1,0, corr=20+edge -> min 26, latency 9.
        cfg_length = 8'd3;
        cfg_frames = 8'd1;
        start = 1; corr = 8'd20;
        tick();
        start = 0;
        lat = 0;
        while (!rif.res_valid && lat < 30) begin
            lat++;
            pos  = lat[0];
            neg  = lat[0];
            corr = 8'(20 + lat);
            tick();
        end
        chk("tie_latency", lat, 9);
        chk("tie_dir", rif.res_dir, DIR_TIE);
        chk("tie_pos_cnt", rif.res_pos_cnt, 16'd1);
        chk("tie_neg_cnt", rif.res_neg_cnt, 16'd1);
        chk("tie_min", rif.res_corr_min, 8'd26);
        h_dir = rif.res_dir; h_pc = rif.res_pos_cnt;
        h_nc = rif.res_neg_cnt; h_min = rif.res_corr_min;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pos = ~pos; corr = corr - 8'd5;
            tick();
            if (!rif.res_valid || rif.res_dir !== h_dir || rif.res_pos_cnt !== h_pc ||
                rif.res_neg_cnt !== h_nc || rif.res_corr_min !== h_min)
                stable = 1'b0;
        end
        chk("backpressure_stable", stable, 1'b1);
        rif.res_ready = 1;
        tick();
        rif.res_ready = 0;
        chk("handshake_valid_drop", rif.res_valid, 1'b0);
        chk("handshake_busy", busy, 1'b0);
        chk("hold_after_idle_min", rif.res_corr_min, 8'd26);

        // Config rejection.
        cfg_length = 8'd1; cfg_frames = 8'd5; start = 1;
        tick();
        start = 0;
        chk("rej_len_err", cfg_err, 1'b1);
        chk("rej_len_busy", busy, 1'b0);
        chk("rej_len_corr_length", corr_length, 8'd3);
        tick();
        chk("rej_len_err_pulse", cfg_err, 1'b0);
        chk("rej_len_busy2", busy, 1'b0);
        cfg_length = 8'd4; cfg_frames = 8'd0; start = 1;
        tick();
        start = 0;
        chk("rej_frm_err", cfg_err, 1'b1);
        chk("rej_frm_corr_length", corr_length, 8'd3);
        tick();
        chk("rej_frm_err_pulse", cfg_err, 1'b0);
        chk("rej_frm_busy", busy, 1'b0);

        // Abort on MEASURE cycle 10: L=8, F=4, MEASURE from edge 10.
        cfg_length = 8'd8; cfg_frames = 8'd4; pos = 1; neg = 0; corr = 8'd40;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 19; k++) tick();
        chk("abort_pre_busy", busy, 1'b1);
        chk("abort_pre_corr_rst", corr_rst, 1'b0);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_corr_rst", corr_rst, 1'b1);
        chk("abort_busy", busy, 1'b0);
        seen = rif.res_valid;
        for (int k = 0; k < 60; k++) begin
            tick();
            seen = seen | rif.res_valid;
        end
        chk("abort_no_result", seen, 1'b0);
        cfg_length = 8'd2; cfg_frames = 8'd1; pos = 0; neg = 1; corr = 8'd50;
        start = 1;
        tick();
        start = 0;
        wait_valid_main(30, lat);
        chk("post_abort_latency", lat, 7);
        chk("post_abort_dir", rif.res_dir, DIR_NEG);
        chk("post_abort_pos_cnt", rif.res_pos_cnt, 16'd0);
        chk("post_abort_neg_cnt", rif.res_neg_cnt, 16'd2);
        chk("post_abort_min", rif.res_corr_min, 8'd50);
        rif.res_ready = 1;
        tick();
        rif.res_ready = 0;
        chk("post_abort_done", rif.res_valid, 1'b0);

        // Saturation on the 4-bit instance: 20 pos votes clamp at 15.
        cfg_length = 8'd10; cfg_frames = 8'd2; pos = 1; neg = 0;
        start_s = 1;
        tick();
        start_s = 0;
        wait_valid_sat(60, lat);
        chk("sat_latency", lat, 33);
        chk("sat_pos_cnt", sif.res_pos_cnt, 4'd15);
        chk("sat_neg_cnt", sif.res_neg_cnt, 4'd0);
        chk("sat_dir", sif.res_dir, DIR_POS);
        sif.res_ready = 1;
        tick();
        sif.res_ready = 0;
        chk("sat_done", sif.res_valid, 1'b0);

        // Asynchronous reset during FILL.
        cfg_length = 8'd5; cfg_frames = 8'd1;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("fill_corr_rst_low", corr_rst, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_corr_rst", corr_rst, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_corr_length", corr_length, 8'd2);
        chk("arst_valid", rif.res_valid, 1'b0);
        chk("arst_dir", rif.res_dir, 2'b00);
        chk("arst_pos_cnt", rif.res_pos_cnt, 16'd0);
        chk("arst_min", rif.res_corr_min, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        cfg_length = 8'd3; cfg_frames = 8'd1;
        start = 1;
        tick();
        start = 0;
        chk("arst_restart_busy", busy, 1'b1);
        chk("arst_restart_length", corr_length, 8'd3);
        wait_valid_main(30, lat);
        chk("arst_restart_latency", lat, 9);
        rif.res_ready = 1;
        tick();
        rif.res_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
